// File: rtl/fifo_drain_ctrl_if.sv
// Bundles the FIFO read side and the downstream write side of the drain controller.
// master = controller; slave = FIFO/downstream environment.
interface fifo_drain_ctrl_if #(
    parameter int LINE_SIZE = 12
);
    logic                 fifo_push;
    logic [LINE_SIZE-1:0] fifo_data_out;
    logic                 fifo_pop;
    logic                 dn_almost_full;
    logic                 dn_push;
    logic [LINE_SIZE-1:0] dn_data;

    modport master (
        input  fifo_push,
        input  fifo_data_out,
        input  dn_almost_full,
        output fifo_pop,
        output dn_push,
        output dn_data
    );

    modport slave (
        output fifo_push,
        output fifo_data_out,
        output dn_almost_full,
        input  fifo_pop,
        input  dn_push,
        input  dn_data
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: tracks FIFO occupancy and forwards popped words downstream.
// Latency: pop in t, data sampled end of t+1, dn_push/dn_data in t+2; one word per cycle.
// Backpressure: dn_almost_full stops new pops at once; words already popped still drain.
module fifo_drain_ctrl #(
    parameter int LINE_SIZE    = 12,
    parameter int DEPTH        = 8,
    parameter int CNT_SIZE     = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    fifo_drain_ctrl_if.master   bus,
    output logic [CNT_SIZE-1:0] occupancy,
    output logic                idle,
    output logic                overflow_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [CNT_SIZE-1:0] DEPTH_C  = CNT_SIZE'(DEPTH);
    localparam logic [1:0]          MAX_IF_C = 2'(MAX_INFLIGHT);

    state_t               state;
    logic                 s1_vld;
    logic                 dn_push_q;
    logic [LINE_SIZE-1:0] dn_data_q;
    logic [CNT_SIZE-1:0]  occ_nxt;
    logic [1:0]           inflight;
    logic                 pop;

    // Only the read-latency stage counts as in flight; the word on dn_push is already forwarded.
    assign inflight = {1'b0, s1_vld};

    assign pop = (state == DRAIN) && (occupancy != '0) && !bus.dn_almost_full
                 && (inflight < MAX_IF_C);

    assign bus.fifo_pop = pop;
    assign bus.dn_push  = dn_push_q && !reset;
    assign bus.dn_data  = dn_data_q;
    assign idle         = (state == IDLE) && !s1_vld && !dn_push_q;

    always_comb begin
        occ_nxt = occupancy;
        if (bus.fifo_push && !pop) begin
            if (occupancy != DEPTH_C) begin
                occ_nxt = occupancy + 1'b1;
            end
        end else if (!bus.fifo_push && pop) begin
            occ_nxt = occupancy - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            occupancy    <= '0;
            overflow_err <= 1'b0;
            s1_vld       <= 1'b0;
            dn_push_q    <= 1'b0;
            dn_data_q    <= '0;
        end else begin
            occupancy <= occ_nxt;
            if (bus.fifo_push && !pop && (occupancy == DEPTH_C)) begin
                overflow_err <= 1'b1;
            end

            s1_vld    <= pop;
            dn_push_q <= s1_vld;
            if (s1_vld) begin
                dn_data_q <= bus.fifo_data_out;
            end

            // IDLE looks at next occupancy so a pop can follow a push by one cycle.
            case (state)
                IDLE: begin
                    if (enable && (occ_nxt != '0)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.dn_almost_full || !enable) begin
                        state <= STALL;
                    end else if ((occ_nxt == '0) && !s1_vld && !pop) begin
                        state <= IDLE;
                    end
                end
                STALL: begin
                    if (!bus.dn_almost_full && enable) begin
                        state <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
